// File: rtl/fifo_sync_dualmode.sv
// Single-clock FIFO with elaboration-time read mode (registered or first-word-fall-through),
// occupancy count, programmable almost flags and sticky overflow/underflow.
module fifo_sync_dualmode #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned LOOKAHEAD  = 0,
    parameter int unsigned AF_THRESH  = (1 << DEPTH_LOG2) - 1,
    parameter int unsigned AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DepthCnt = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CntOne   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PtrOne   = DEPTH_LOG2'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_q;
    logic [31:0]           count_ext;
    logic                  wr_ok;
    logic                  rd_ok;

    // All status is decoded from the registered count, never from pointer compare.
    assign count_ext    = 32'(count_q);
    assign full         = (count_q == DepthCnt);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_ext >= AF_THRESH);
    assign almost_empty = (count_ext <= AE_THRESH);
    assign count        = count_q;

    assign wr_ok = wr && !full;
    assign rd_ok = rd && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PtrOne;
            if (rd_ok) rd_ptr <= rd_ptr + PtrOne;
            if (wr_ok && !rd_ok) begin
                count_q <= count_q + CntOne;
            end else if (rd_ok && !wr_ok) begin
                count_q <= count_q - CntOne;
            end
            if (wr && full)  overflow  <= 1'b1;
            if (rd && empty) underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !rst) mem[wr_ptr] <= din;
    end

    if (LOOKAHEAD != 0) begin : g_fwft
        assign dout = mem[rd_ptr];
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] dout_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q <= '0;
            end else if (rd_ok) begin
                dout_q <= mem[rd_ptr];
            end
        end
        assign dout = dout_q;
    end

endmodule

// File: tb/tb_fifo_sync_dualmode.sv
// Drives a registered-read and a lookahead instance with identical stimulus and checks both
// against a queue-based model of the FIFO.
module tb_fifo_sync_dualmode;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr  = 1'b0;
    logic       rd  = 1'b0;
    logic [7:0] din = 8'h00;

    logic [7:0] n_dout, l_dout;
    logic [3:0] n_count, l_count;
    logic       n_full, n_af, n_empty, n_ae, n_ovf, n_unf;
    logic       l_full, l_af, l_empty, l_ae, l_ovf, l_unf;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    logic [7:0] m_dn  = 8'h00;

    always #5 clk = ~clk;

    fifo_sync_dualmode #(
        .DATA_WIDTH(8), .DEPTH_LOG2(3), .LOOKAHEAD(0), .AF_THRESH(6), .AE_THRESH(1)
    ) u_nla (
        .clk(clk), .rst(rst), .wr(wr), .din(din), .full(n_full), .almost_full(n_af),
        .rd(rd), .dout(n_dout), .empty(n_empty), .almost_empty(n_ae), .count(n_count),
        .overflow(n_ovf), .underflow(n_unf)
    );

    fifo_sync_dualmode #(
        .DATA_WIDTH(8), .DEPTH_LOG2(3), .LOOKAHEAD(1), .AF_THRESH(6), .AE_THRESH(1)
    ) u_la (
        .clk(clk), .rst(rst), .wr(wr), .din(din), .full(l_full), .almost_full(l_af),
        .rd(rd), .dout(l_dout), .empty(l_empty), .almost_empty(l_ae), .count(l_count),
        .overflow(l_ovf), .underflow(l_unf)
    );

    // One clock with the given request; the model follows the FIFO rules on the same edge.
    task automatic step(input logic w, input logic [7:0] d, input logic r);
        int n;
        wr = w; din = d; rd = r;
        @(posedge clk);
        n = q.size();
        if (w && n == 8) m_ovf = 1'b1;
        if (r && n == 0) m_unf = 1'b1;
        if (r && n > 0) m_dn = q.pop_front();
        if (w && n < 8) q.push_back(d);
        #1;
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr = 1'b1; rd = 1'b1; din = 8'($urandom);
        @(posedge clk);
        q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_dn = 8'h00;
        #1;
        rst = 1'b0; wr = 1'b0; rd = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({n_count, n_empty, n_full, n_ae, n_af, n_ovf, n_unf} !== {4'd0, 6'b101000}) begin
            errors++;
            $display("FAIL reset_nla_status got %b want %b",
                     {n_count, n_empty, n_full, n_ae, n_af, n_ovf, n_unf}, {4'd0, 6'b101000});
        end
        checks++;
        if ({l_count, l_empty, l_full, l_ae, l_af, l_ovf, l_unf} !== {4'd0, 6'b101000}) begin
            errors++;
            $display("FAIL reset_la_status got %b want %b",
                     {l_count, l_empty, l_full, l_ae, l_af, l_ovf, l_unf}, {4'd0, 6'b101000});
        end
        checks++;
        if (n_dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_dout got %h want 00", n_dout);
        end
    endtask

    task automatic test_order();
        logic [7:0] src[8] = '{8'h5A, 8'hF6, 8'h09, 8'hC4, 8'h81, 8'hE2, 8'hA0, 8'h7A};
        logic [7:0] got[$];
        int wi = 0;
        int cyc = 0;
        logic w, r;
        do_reset();
        while ((wi < 8 || q.size() > 0) && cyc < 400) begin
            w = (wi < 8) && ($urandom_range(0, 1) == 1);
            r = (q.size() > 0) && ($urandom_range(0, 2) == 0);
            step(w, w ? src[wi] : 8'($urandom), r);
            if (w) wi++;
            if (r) got.push_back(n_dout);
            cyc++;
            checks++;
            if (n_dout !== m_dn) begin
                errors++;
                $display("FAIL order_nla_dout cyc %0d got %h want %h", cyc, n_dout, m_dn);
            end
            if (q.size() > 0) begin
                checks++;
                if (l_dout !== q[0]) begin
                    errors++;
                    $display("FAIL order_la_dout cyc %0d got %h want %h", cyc, l_dout, q[0]);
                end
            end
            checks++;
            if (n_count !== 4'(q.size()) || l_count !== 4'(q.size())) begin
                errors++;
                $display("FAIL order_count cyc %0d got %0d/%0d want %0d",
                         cyc, n_count, l_count, q.size());
            end
        end
        checks++;
        if (got.size() != 8) begin
            errors++;
            $display("FAIL order_pops got %0d want 8", got.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got[i] !== src[i]) begin
                    errors++;
                    $display("FAIL order_seq idx %0d got %h want %h", i, got[i], src[i]);
                end
            end
        end
        checks++;
        if ({n_ovf, n_unf, l_ovf, l_unf} !== 4'b0000) begin
            errors++;
            $display("FAIL order_errs got %b want 0000", {n_ovf, n_unf, l_ovf, l_unf});
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 8'(i + 1), 1'b0);
        checks++;
        if ({n_full, n_count, n_ovf} !== {1'b1, 4'd8, 1'b0}) begin
            errors++;
            $display("FAIL fill_full got %b want %b", {n_full, n_count, n_ovf}, {1'b1, 4'd8, 1'b0});
        end
        step(1'b1, 8'hEE, 1'b0);
        checks++;
        if ({n_ovf, l_ovf, n_count} !== {2'b11, 4'd8}) begin
            errors++;
            $display("FAIL overflow_flag got %b want %b", {n_ovf, l_ovf, n_count}, {2'b11, 4'd8});
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (l_dout !== 8'(i + 1)) begin
                errors++;
                $display("FAIL ovf_la_head idx %0d got %h want %h", i, l_dout, 8'(i + 1));
            end
            step(1'b0, 8'h00, 1'b1);
            checks++;
            if (n_dout !== 8'(i + 1)) begin
                errors++;
                $display("FAIL ovf_drain idx %0d got %h want %h", i, n_dout, 8'(i + 1));
            end
        end
    endtask

    task automatic test_simul();
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        step(1'b1, 8'hEE, 1'b1);
        checks++;
        if ({n_count, n_ovf, n_dout} !== {4'd7, 1'b1, 8'h10}) begin
            errors++;
            $display("FAIL full_wr_rd got %h want %h", {n_count, n_ovf, n_dout}, {4'd7, 1'b1, 8'h10});
        end
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h77, 1'b1);
        checks++;
        if (n_count !== 4'd4 || n_dout !== m_dn) begin
            errors++;
            $display("FAIL mid_wr_rd got %0d/%h want 4/%h", n_count, n_dout, m_dn);
        end
        while (q.size() > 0) begin
            step(1'b0, 8'h00, 1'b1);
            checks++;
            if (n_dout !== m_dn) begin
                errors++;
                $display("FAIL simul_drain got %h want %h", n_dout, m_dn);
            end
        end
    endtask

    task automatic test_underflow();
        logic [7:0] d;
        do_reset();
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if ({n_unf, l_unf, n_count, n_empty} !== {2'b11, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL underflow got %b want %b", {n_unf, l_unf, n_count, n_empty},
                     {2'b11, 4'd0, 1'b1});
        end
        d = 8'($urandom);
        step(1'b1, d, 1'b1);
        checks++;
        if ({n_count, l_empty, l_dout, n_unf} !== {4'd1, 1'b0, d, 1'b1}) begin
            errors++;
            $display("FAIL empty_wr_rd got %h want %h", {n_count, l_empty, l_dout, n_unf},
                     {4'd1, 1'b0, d, 1'b1});
        end
    endtask

    task automatic test_thresholds();
        logic [3:0] exp;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(i < 8, 8'($urandom), i >= 8);
            exp = {q.size() == 8, q.size() == 0, q.size() >= 6, q.size() <= 1};
            checks++;
            if ({n_full, n_empty, n_af, n_ae} !== exp || {l_af, l_ae} !== exp[1:0]) begin
                errors++;
                $display("FAIL thresh cnt %0d got %b want %b", q.size(),
                         {n_full, n_empty, n_af, n_ae}, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic w, r;
        do_reset();
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        checks++;
        if ({n_count, n_ovf, n_unf} !== {4'd5, 2'b11}) begin
            errors++;
            $display("FAIL premid got %b want %b", {n_count, n_ovf, n_unf}, {4'd5, 2'b11});
        end
        do_reset();
        checks++;
        if ({n_count, l_count, n_empty, n_ovf, n_unf, l_ovf, l_unf} !== {8'd0, 5'b10000}) begin
            errors++;
            $display("FAIL mid_reset got %b want %b",
                     {n_count, l_count, n_empty, n_ovf, n_unf, l_ovf, l_unf}, {8'd0, 5'b10000});
        end
        for (int i = 0; i < 40; i++) begin
            w = (q.size() < 8) && ($urandom_range(0, 2) != 0);
            r = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            step(w, 8'($urandom), r);
            checks++;
            if (n_dout !== m_dn || n_count !== 4'(q.size())) begin
                errors++;
                $display("FAIL wrap_nla cyc %0d got %h/%0d want %h/%0d",
                         i, n_dout, n_count, m_dn, q.size());
            end
            if (q.size() > 0) begin
                checks++;
                if (l_dout !== q[0]) begin
                    errors++;
                    $display("FAIL wrap_la cyc %0d got %h want %h", i, l_dout, q[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_order();
        test_order();
        test_overflow();
        test_simul();
        test_underflow();
        test_thresholds();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
